// File: rtl/countdown_timer.sv
// Single-shot / periodic countdown timer with registered terminal-count DONE pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic (auto-reload) mode; default build is single-shot.
module countdown_timer #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
  input  logic                     START,
  input  logic                     ENABLE,
  input  logic                     ABORT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [COUNTER_WIDTH-1:0] COUNT
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_count;
  logic [COUNTER_WIDTH-1:0] r_reload;
  logic                     r_done;

  state_t                   w_next_state;
  logic [COUNTER_WIDTH-1:0] w_next_count;
  logic [COUNTER_WIDTH-1:0] w_next_reload;
  logic                     w_next_done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_reload <= w_next_reload;
      r_done   <= w_next_done;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_reload = r_reload;
    w_next_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // ABORT in IDLE only matters as a blocker of START.
        if (START && !ABORT) begin
          if (LOAD_VALUE != '0) begin
            w_next_count  = LOAD_VALUE;
            w_next_reload = LOAD_VALUE;
            w_next_state  = RUN;
          end else begin
            w_next_count = '0;
            w_next_done  = 1'b1;
          end
        end
      end
      RUN: begin
        if (ABORT) begin
          w_next_count = '0;
          w_next_state = IDLE;
        end else if (ENABLE) begin
          if (r_count > COUNTER_WIDTH'(1)) begin
            w_next_count = r_count - COUNTER_WIDTH'(1);
          end else begin
            // Terminal tick: COUNT is never 0 in RUN, so this is COUNT==1.
            w_next_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_next_count = r_reload;
`else
            w_next_count = '0;
            w_next_state = IDLE;
`endif
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_count = '0;
      end
    endcase
  end

  assign BUSY  = (r_state == RUN);
  assign DONE  = r_done;
  assign COUNT = r_count;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, reset/auto-reload sequences,
// and randomized traffic against a behavioural model.
module tb_countdown_timer;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] LOAD_VALUE = '0;
  logic         START = 1'b0;
  logic         ENABLE = 1'b0;
  logic         ABORT = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] COUNT;

  int vectors = 0;
  int miscompares = 0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  countdown_timer #(.COUNTER_WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD_VALUE(LOAD_VALUE), .START(START),
    .ENABLE(ENABLE), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         start;
    logic         enable;
    logic         abort;
    logic [W-1:0] load;
    logic [W-1:0] exp_count;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  // Behavioural model state
  bit m_run;
  int m_count;
  int m_reload;
  bit m_done;

  task automatic check(input string name, input logic [W-1:0] ec, input logic eb, input logic ed);
    vectors++;
    if (COUNT !== ec || BUSY !== eb || DONE !== ed) begin
      miscompares++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b, expected count=%0d busy=%0b done=%0b",
               name, COUNT, BUSY, DONE, ec, eb, ed);
    end
  endtask

  task automatic apply(input logic s, input logic e, input logic a, input logic [W-1:0] l);
    @(negedge CLK);
    START = s; ENABLE = e; ABORT = a; LOAD_VALUE = l;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step(input logic s, input logic e, input logic a, input int l);
    m_done = 1'b0;
    if (!m_run) begin
      if (s && !a) begin
        if (l == 0) m_done = 1'b1;
        else begin
          m_count = l; m_reload = l; m_run = 1'b1;
        end
      end
    end else if (a) begin
      m_count = 0; m_run = 1'b0;
    end else if (e) begin
      if (m_count == 1) begin
        m_done = 1'b1;
        if (AUTO) m_count = m_reload;
        else begin
          m_count = 0; m_run = 1'b0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; START = 0; ENABLE = 0; ABORT = 0; LOAD_VALUE = '0;
    @(negedge CLK);
    RESET = 1'b0;
    m_run = 0; m_count = 0; m_reload = 0; m_done = 0;
  endtask

  vec_t tbl[$];

  initial begin
    // Reset state
    #12;
    check("reset_state", '0, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // start, enable, abort, load, count, busy, done
    tbl.push_back('{1, 1, 0, 3, 3, 1, 0}); // single-shot 3
    tbl.push_back('{0, 1, 0, 0, 2, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 2, 2, 1, 0}); // gated ticks
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 9, 1, 1, 0}); // START in RUN ignored
    tbl.push_back('{0, 1, 0, 9, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1}); // zero load
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 4, 4, 1, 0}); // abort on terminal edge
    tbl.push_back('{0, 1, 0, 0, 3, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 2, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 5, 0, 0, 0}); // START+ABORT in IDLE
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      apply(tbl[i].start, tbl[i].enable, tbl[i].abort, tbl[i].load);
      check($sformatf("table[%0d]", i), tbl[i].exp_count, tbl[i].exp_busy, tbl[i].exp_done);
    end
`else
    begin
      logic [W-1:0] exp_c[7] = '{2, 1, 2, 1, 2, 1, 2};
      logic         exp_d[7] = '{0, 0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        apply(i == 0, 1'b1, 1'b0, 16'd2);
        check($sformatf("autoreload[%0d]", i), exp_c[i], 1'b1, exp_d[i]);
      end
      apply(1'b0, 1'b1, 1'b1, '0);
      check("autoreload_abort", '0, 1'b0, 1'b0);
    end
`endif

    // Asynchronous reset mid-countdown at COUNT=5
    apply(1'b1, 1'b0, 1'b0, 16'd5);
    check("pre_reset_run", 16'd5, 1'b1, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", '0, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    START = 1'b0;
    ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, '0);
      check("post_reset_quiet", '0, 1'b0, 1'b0);
    end
    // START accepted on the first edge after reset release
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; START = 1'b1; ENABLE = 1'b0; ABORT = 1'b0; LOAD_VALUE = 16'd3;
    @(posedge CLK);
    #1;
    check("start_after_reset", 16'd3, 1'b1, 1'b0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic s, e, a;
      logic [W-1:0] l;
      s = ($urandom_range(0, 9) < 3);
      e = ($urandom_range(0, 9) < 6);
      a = ($urandom_range(0, 19) == 0);
      l = W'($urandom_range(0, 5));
      model_step(s, e, a, int'(l));
      apply(s, e, a, l);
      check($sformatf("random[%0d]", i), W'(m_count), m_run, m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
